multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
Control unit for the multicycle RV32I core, the successor to the single-cycle controller/datapath pairing. It sequences each instruction through fetch/decode/execute/memory/writeback states over a shared instruction/data memory with a req/ready handshake. It drives all datapath selects and enables, and adds configurable memory-wait timeout, fault trapping and an optional retired-instruction counter.

Parameters:
ALUCTRL_W, 3, width of ALUControl
TIMEOUT_CYCLES, 255, max consecutive MemReq&&!MemReady cycles before FAULT; 0 disables timeout
CNT_W, 32, width of InstRet counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
op  in  7  Instr[6:0] from instruction register
funct3  in  3  Instr[14:12]
funct7b5  in  1  Instr[30]
Zero  in  1  ALU result == 0
Neg  in  1  ALU signed-less-than flag
MemReady  in  1  memory completes the current access this cycle
MemReq  out  1  memory access request
MemWrite  out  1  store request (valid only with MemReq)
IRWrite  out  1  load instruction register / OldPC
PCWrite  out  1  PC update enable
RegWrite  out  1  register file write enable
AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1
ALUSrcB  out  2  00 rs2, 01 imm, 10 constant 4
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J; decoded combinationally from op in every state
ALUControl  out  ALUCTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt
Trap  out  1  high while in FAULT
InstRet  out  CNT_W  retired-instruction count

Behaviour:
- Reset low: immediately enter FETCH; all enables, MemReq and Trap are 0; selects are 0; counters are 0. Outputs stay at these values until the first clk edge after reset release.
- Outputs are Moore by state, except for the handshake-qualified enables listed per state.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite and PCWrite are asserted only in the cycle MemReady=1; on that cycle go to DECODE, otherwise hold.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jump target into ALUOut). Next state by op:
  - 0000011 / 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> FAULT
- MEMADR: ALUSrcA=10, ALUSrcB=01, add; go to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: MemReq=1, AdrSrc=1; go to MEMWB on MemReady.
- MEMWB: ResultSrc=01, RegWrite=1; -> FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1; go to FETCH on MemReady (store retires).
- EXECUTER: ALUSrcA=10, ALUSrcB=00. EXECUTEI: ALUSrcA=10, ALUSrcB=01. Both -> ALUWB.
- ALU decode in EXECUTER/EXECUTEI, by funct3:
  - 000: sub only if op[5]&funct7b5, else add
  - 010: slt
  - 110: or
  - 111: and
  - any other funct3 -> FAULT instead of ALUWB
- ALUWB: ResultSrc=00, RegWrite=1; -> FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = taken: funct3 000 Zero, 001 !Zero, 100 Neg, 101 !Neg.
  - Any other funct3 -> FAULT with PCWrite=0.
  - Otherwise -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; -> ALUWB (rd <- OldPC+4).
- Handshake:
  - MemReq, AdrSrc and MemWrite stay stable from assertion until the MemReady cycle.
  - MemReady while MemReq=0 is ignored.
  - MemReady may be high in the first request cycle (zero-wait access).
- Timeout: the wait counter increments each cycle MemReq&&!MemReady and clears on MemReady or state exit. When it reaches TIMEOUT_CYCLES (if nonzero), go to FAULT on the next edge.
- FAULT: all enables and MemReq are 0, Trap=1; absorbing until reset.
- InstRet increments by 1 on each transition into FETCH from MEMWB, ALUWB, MEMWRITE or BRANCH. It wraps modulo 2^CNT_W.

Optional Feature:
INSTRET_CNT_EN
- Defined: InstRet counter implemented as above.
- Undefined: no counter register; InstRet is tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
- Reset release, MemReady=1 constant, op=0110011 funct3=000 funct7b5=1 -> FETCH, DECODE, EXECUTER (ALUControl=001), ALUWB (RegWrite=1), FETCH; InstRet=1.
- lw (op=0000011) with MemReady held 0 for 3 cycles in MEMREAD -> MemReq=1 and AdrSrc=1 stable for 4 cycles, then MEMWB with ResultSrc=01 and RegWrite=1.
- beq (funct3=000) with Zero=1 -> PCWrite=1 in BRANCH; with Zero=0 -> PCWrite=0; both return to FETCH.
- jal (op=1101111) -> PCWrite=1 in JAL, then ALUWB with RegWrite=1; ImmSrc=11 throughout.
- TIMEOUT_CYCLES=4, MemReady stuck 0 in FETCH -> FAULT after 4 wait cycles, Trap=1 and MemReq=0 permanently; op=0000000 at DECODE -> FAULT.
- Drive reset low mid-MEMWRITE -> MemReq and MemWrite drop to 0 asynchronously; after release, FETCH with InstRet=0.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : RV32I multicycle control FSM over a shared req/ready memory, with
//            memory-wait timeout, fault trap and optional retired-instruction
//            counter (enabled by defining INSTRET_CNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
  parameter int ALUCTRL_W      = 3,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 Neg,
  input  logic                 MemReady,
  output logic                 MemReq,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Trap,
  output logic [CNT_W-1:0]     InstRet
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_FAULT    = 4'd11
  } state_t;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(5);
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t              state_q, state_d;
  logic                run_q;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                w_wait, w_timeout, w_alu_bad, w_taken, w_br_bad;
  logic [ALUCTRL_W-1:0] w_alu_ctrl;
  logic [1:0]          w_imm;

  // run_q keeps every output quiet between reset release and the first edge.
  assign w_wait = run_q && !MemReady &&
                  (state_q == S_FETCH || state_q == S_MEMREAD || state_q == S_MEMWRITE);

  // Fault on the edge that closes the TIMEOUT_CYCLES-th consecutive wait cycle.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      assign w_timeout = w_wait && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  assign wait_d = (w_wait && !w_timeout) ? wait_q + 1'b1 : '0;

  always_comb begin
    w_alu_ctrl = ALU_ADD;
    w_alu_bad  = 1'b0;
    case (funct3)
      3'b000:  w_alu_ctrl = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  w_alu_ctrl = ALU_SLT;
      3'b110:  w_alu_ctrl = ALU_OR;
      3'b111:  w_alu_ctrl = ALU_AND;
      default: w_alu_bad  = 1'b1;
    endcase
  end

  always_comb begin
    w_taken  = 1'b0;
    w_br_bad = 1'b0;
    case (funct3)
      3'b000:  w_taken  = Zero;
      3'b001:  w_taken  = !Zero;
      3'b100:  w_taken  = Neg;
      3'b101:  w_taken  = !Neg;
      default: w_br_bad = 1'b1;
    endcase
  end

  always_comb begin
    case (op)
      7'b0100011: w_imm = 2'b01;
      7'b1100011: w_imm = 2'b10;
      7'b1101111: w_imm = 2'b11;
      default:    w_imm = 2'b00;
    endcase
  end

  assign ImmSrc = run_q ? w_imm : 2'b00;

  always_comb begin
    state_d    = state_q;
    MemReq     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    Trap       = 1'b0;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          MemReq    = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = MemReady;
          PCWrite   = MemReady;
          if (MemReady) state_d = S_DECODE;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          case (op)
            7'b0000011, 7'b0100011: state_d = S_MEMADR;
            7'b0110011:             state_d = S_EXECR;
            7'b0010011:             state_d = S_EXECI;
            7'b1100011:             state_d = S_BRANCH;
            7'b1101111:             state_d = S_JAL;
            default:                state_d = S_FAULT;
          endcase
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          MemReq = 1'b1;
          AdrSrc = 1'b1;
          if (MemReady) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
          state_d   = S_FETCH;
        end
        S_MEMWRITE: begin
          MemReq   = 1'b1;
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
          if (MemReady) state_d = S_FETCH;
        end
        S_EXECR, S_EXECI: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
          ALUControl = w_alu_ctrl;
          state_d    = w_alu_bad ? S_FAULT : S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          state_d  = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUControl = ALU_SUB;
          PCWrite    = w_taken;
          state_d    = w_br_bad ? S_FAULT : S_FETCH;
        end
        S_JAL: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          PCWrite = 1'b1;
          state_d = S_ALUWB;
        end
        S_FAULT: Trap = 1'b1;
        default: begin
          Trap    = 1'b1;
          state_d = S_FAULT;
        end
      endcase
      if (w_timeout) state_d = S_FAULT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      wait_q  <= wait_d;
    end
  end

`ifdef INSTRET_CNT_EN
  logic [CNT_W-1:0] instret_q;
  logic             w_retire;

  assign w_retire = (state_d == S_FETCH) &&
                    (state_q == S_MEMWB || state_q == S_ALUWB ||
                     state_q == S_MEMWRITE || state_q == S_BRANCH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) instret_q <= '0;
    else if (w_retire) instret_q <= instret_q + 1'b1;
  end

  assign InstRet = instret_q;
`else
  assign InstRet = '0;
`endif

endmodule
`default_nettype wire
